// File: rtl/grass_pkg.sv
// Shared constants and GF(2^8) arithmetic for the Kuznyechik linear layer.
package grass_pkg;

   localparam int BLOCK_W = 128;
   localparam logic [7:0] GF_POLY = 8'hC3;
   localparam logic [4:0] R_STEPS_TOTAL = 5'd16;

   // L_COEF[0] multiplies byte a15, L_COEF[15] multiplies byte a0.
   localparam logic [7:0] L_COEF [0:15] = '{
      8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
      8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } l_state_e;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = '0;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
      end
      return acc;
   endfunction

endpackage

// File: rtl/l_transform_if.sv
// Valid/ready input and output channels of the L-transform block.
interface l_transform_if;
   import grass_pkg::*;

   logic               valid_i;
   logic               ready_o;
   logic [BLOCK_W-1:0] data_i;
   logic               valid_o;
   logic               ready_i;
   logic [BLOCK_W-1:0] data_o;

   modport slave (
      input  valid_i, data_i, ready_i,
      output ready_o, valid_o, data_o
   );

   modport master (
      output valid_i, data_i, ready_i,
      input  ready_o, valid_o, data_o
   );

endinterface

// File: rtl/l_transform_r_step.sv
// One combinational R-step: compute the linear byte l and shift it in at the top.
module r_step
   import grass_pkg::*;
(
   input  logic [BLOCK_W-1:0] data_i,
   output logic [BLOCK_W-1:0] data_o
);

   logic [7:0] l;

   always_comb begin
      l = '0;
      // NOTE: blocking assignments inside always_comb build a combinational chain; never use them in always_ff.
      for (int i = 0; i < 16; i++) begin
         l = l ^ gf_mul(L_COEF[15-i], data_i[8*i +: 8]);
      end
   end

   assign data_o = {l, data_i[BLOCK_W-1:8]};

endmodule

// File: rtl/l_transform.sv
// Iterative L = R^16 with ROUNDS_PER_CYCLE chained R-steps per clock and valid/ready handshakes.
module l_transform
   import grass_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   l_transform_if.slave bus
);

   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
         ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
      $error("l_transform: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

   l_state_e           state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [BLOCK_W-1:0] work_q, work_d;
   logic [BLOCK_W-1:0] chain [ROUNDS_PER_CYCLE+1];

   assign chain[0] = work_q;

   for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_step
      r_step u_r_step (
         .data_i (chain[i]),
         .data_o (chain[i+1])
      );
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every signal and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.valid_i) begin
               work_d  = bus.data_i;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            work_d = chain[ROUNDS_PER_CYCLE];
            cnt_d  = cnt_q + STEP;
            if (cnt_d == R_STEPS_TOTAL) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (bus.ready_i) begin
               if (bus.valid_i) begin
                  work_d  = bus.data_i;
                  cnt_d   = '0;
                  state_d = ST_BUSY;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs depend only on state and ready_i, never on valid_i.
   assign bus.ready_o = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.ready_i);
   assign bus.valid_o = (state_q == ST_DONE);
   assign bus.data_o  = work_q;

endmodule

// File: doc/l_transform.md
Name: l_transform

Overview:
Iterative Kuznyechik (GOST R 34.12-2015) linear transform L = R^16. It sits directly downstream of the byte-substitution (S) stage, consumes its 128-bit output, and produces the L-transformed block for the next round-key XOR. Each cycle applies ROUNDS_PER_CYCLE R-steps, trading area against latency. The block uses a valid/ready handshake on both input and output.

Parameters:
ROUNDS_PER_CYCLE, 1, R-steps applied per clock; legal values 1, 2, 4, 8, 16. Any other value is an elaboration error.

Ports:
clk      input   1    clock, all state updates on rising edge
rst      input   1    asynchronous, active-high reset
valid_i  input   1    data_i valid
ready_o  output  1    block can accept data_i this cycle
data_i   input   128  block from S stage; byte a15 = [127:120] ... a0 = [7:0]
valid_o  output  1    data_o holds finished L(data_i)
ready_i  input   1    downstream accepts data_o
data_o   output  128  working register; meaningful only while valid_o=1

Behaviour:
- R-step on bytes a15..a0: l = 148·a15 ⊕ 32·a14 ⊕ 133·a13 ⊕ 16·a12 ⊕ 194·a11 ⊕ 192·a10 ⊕ 1·a9 ⊕ 251·a8 ⊕ 1·a7 ⊕ 192·a6 ⊕ 194·a5 ⊕ 16·a4 ⊕ 133·a3 ⊕ 32·a2 ⊕ 148·a1 ⊕ 1·a0.
- Multiplication is in GF(2^8) mod x^8+x^7+x^6+x+1 (0x1C3).
- Result of the R-step = {l, a15..a1}: shift right one byte and insert l at [127:120].
- L = 16 successive R-steps.
- States:
  - IDLE: ready_o=1, valid_o=0.
  - BUSY: ready_o=0, valid_o=0.
  - DONE: valid_o=1, ready_o=ready_i.
- Step counter: 5 bits, counts R-steps done.
- IDLE, valid_i=1: capture data_i into the working register, cnt=0, go to BUSY.
- IDLE, valid_i=0: stay in IDLE.
- BUSY, each cycle: the register takes ROUNDS_PER_CYCLE chained R-steps and cnt += ROUNDS_PER_CYCLE. When the new cnt equals 16, go to DONE.
- Latency: acceptance edge to the valid_o rising edge is exactly 16/ROUNDS_PER_CYCLE clocks (16 for default, 1 for 16).
- DONE, ready_i=0:
  - data_o and valid_o hold stable.
  - valid_i is ignored because ready_o=0.
- DONE, ready_i=1, valid_i=1: output is consumed and the new data_i is captured in the same edge, cnt=0, go to BUSY. This gives back-to-back throughput of one block per 16/ROUNDS_PER_CYCLE+1 clocks.
- DONE, ready_i=1, valid_i=0: go to IDLE.
- ready_o is combinational from state and ready_i. No combinational path from valid_i to any output.
- Reset (async, any state, including mid-BUSY):
  - state=IDLE, cnt=0, working register=0.
  - Outputs after reset: valid_o=0, data_o=0, ready_o=1.
  - An in-flight block is discarded and no partial result is ever flagged valid.
- Reset release: first acceptance is possible on the first rising edge with rst=0.
- valid_i asserted during BUSY is ignored. The upstream must hold valid_i/data_i until the ready_o handshake completes.
- All GF arithmetic is byte-wide; no intermediate exceeds 8 bits after reduction.

Decomposition:
- Package grass_pkg holds:
  - BLOCK_W=128;
  - GF_POLY=8'hC3 (low byte of 0x1C3);
  - L_COEF[0:15] = {148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1};
  - a gf_mul function (shift-and-reduce, 8 iterations).
- One sub-module, r_step: combinational single R-step, 128 in/128 out, using the package constants.
- l_transform instantiates ROUNDS_PER_CYCLE r_step copies chained in a generate loop, plus the FSM/counter.

Test Plan:
1. Reset then data_i=64a59400000000000000000000000000, valid_i=1 for one cycle, ready_i=1 -> valid_o rises exactly 16 clocks after acceptance with data_o=d456584dd0e3e84cc3166e4b7fa2890d.
2. ROUNDS_PER_CYCLE=16, data_i=d456584dd0e3e84cc3166e4b7fa2890d -> 1-clock latency, data_o=79d26221b87b584cd42fbc4ffea5de9a. Run ROUNDS_PER_CYCLE=1, 2, 4, 8 with the same vector and check latencies 16, 8, 4, 2.
3. Single-step check: force ROUNDS_PER_CYCLE=1, peek the register after the first BUSY edge with input 00000000000000000000000000000100 -> 94000000000000000000000000000001; next edge -> a5940000000000000000000000000000.
4. Backpressure: ready_i=0 for 20 clocks after valid_o -> data_o/valid_o stable and ready_o=0 throughout. Then ready_i=1 with valid_i=1 and a new block -> same-edge handoff, valid_o drops, and the second result appears 16 clocks later.
5. Assert rst at cnt=7 mid-BUSY -> valid_o=0, data_o=0, ready_o=1 immediately (asynchronous). No spurious valid_o afterwards. A fresh block then completes correctly.
6. Random 1000 blocks with random valid_i/ready_i gaps, checked against a software L model -> no drops, no duplicates, order preserved.
